// File: rtl/impulse_noise_injector.sv
// ---------------------------------------------------------------------------
// impulse_noise_injector
//
// Streaming salt-and-pepper noise source. Each accepted pixel is replaced by
// an impulse (T1 = pepper, T2 = salt) when an LFSR draw falls below the
// programmable density, otherwise it passes through unchanged. Per-beat
// injection flags and saturating counters let a downstream detector/filter
// be scored against the ground truth.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   s_valid/s_ready     input handshake, s_data input pixel
//   density             injection threshold (rnd < density injects, 0 = bypass)
//   m_valid/m_ready     output handshake
//   m_data              output pixel (original or impulse)
//   m_noise             1 when this output beat was injected
//   clr_cnt             synchronous clear of both counters
//   pix_cnt, noise_cnt  saturating accepted / injected pixel counts
// ---------------------------------------------------------------------------
module impulse_noise_injector #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] T1         = '0,
  parameter logic [DATA_WIDTH-1:0] T2         = '1,
  parameter logic [15:0]           SEED       = 16'hACE1,
  parameter int                    CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [7:0]            density,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_noise,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  pix_cnt,
  output logic [CNT_WIDTH-1:0]  noise_cnt
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0]          SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [15:0]           lfsr;
  logic [15:0]           lfsr_next;
  logic                  accept;
  logic                  inject;
  logic [DATA_WIDTH-1:0] pix_out;

  // Single output register: a new pixel may enter whenever the register is
  // empty or is being drained this cycle.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form. The decision uses the
  // advanced value, so the first accepted pixel already sees a fresh draw.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign inject    = lfsr_next[7:0] < density;
  assign pix_out   = inject ? (lfsr_next[8] ? T2 : T1) : s_data;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED_EFF;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_noise   <= 1'b0;
      pix_cnt   <= '0;
      noise_cnt <= '0;
    end else begin
      // The LFSR steps only on accept, so stalls never consume draws.
      if (accept) begin
        lfsr    <= lfsr_next;
        m_data  <= pix_out;
        m_noise <= inject;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      // Clear takes priority over a same-cycle increment.
      if (clr_cnt) begin
        pix_cnt   <= '0;
        noise_cnt <= '0;
      end else if (accept) begin
        if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
        if (inject && noise_cnt != CNT_MAX) noise_cnt <= noise_cnt + 1'b1;
      end
    end
  end

endmodule
